// File: rtl/player_shot_move_if.sv
// Signal bundle between the player shot mover and its neighbours (player mover,
// collision logic, shot drawing).
interface player_shot_move_if;
    // No valid/ready pairs here: startOfFrame is a one-clk strobe, fire and
    // shotHit are levels sampled every clk, and the outputs are registered
    // levels that stay valid until the next update.
    logic        startOfFrame;
    logic        fire;
    logic        shotHit;
    logic [10:0] playerX;
    logic [10:0] playerY;
    logic        shotActive;
    logic [10:0] topLeftX;
    logic [10:0] topLeftY;
    logic [1:0]  shot_state;

    modport slave (
        input  startOfFrame, fire, shotHit, playerX, playerY,
        output shotActive, topLeftX, topLeftY, shot_state
    );

    modport master (
        output startOfFrame, fire, shotHit, playerX, playerY,
        input  shotActive, topLeftX, topLeftY, shot_state
    );
endinterface

// File: rtl/player_shot_move.sv
// Player missile: launches one shot from the muzzle and moves it up once per frame.
// Optional macro PLAYER_SHOT_AUTOFIRE_EN: fire level auto-repeats instead of edge-triggering.
module player_shot_move #(
    parameter int Y_SPEED         = 256,
    parameter int SHOT_OFFSET_X   = 16,
    parameter int SHOT_HEIGHT     = 16,
    parameter int TOP_LIMIT       = 0,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic              clk,
    input  logic              resetN,
    player_shot_move_if.slave bus
);
    localparam int MULTIPLIER = 64;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLYING   = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    state_t state, state_nxt;
    int     x_fx, x_nxt;
    int     y_fx, y_nxt;
    int     cnt, cnt_nxt;
    logic   active, active_nxt;
    logic   fire_req, req_nxt;
    logic   fire_d;
    int     px_int, py_int;

    assign px_int = int'({21'd0, bus.playerX});
    assign py_int = int'({21'd0, bus.playerY});

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            x_fx     <= 0;
            y_fx     <= 0;
            cnt      <= 0;
            active   <= 1'b0;
            fire_req <= 1'b0;
            fire_d   <= 1'b0;
        end else begin
            state    <= state_nxt;
            x_fx     <= x_nxt;
            y_fx     <= y_nxt;
            cnt      <= cnt_nxt;
            active   <= active_nxt;
            fire_req <= req_nxt;
            fire_d   <= bus.fire;
        end
    end

    always_comb begin
        state_nxt  = state;
        x_nxt      = x_fx;
        y_nxt      = y_fx;
        cnt_nxt    = cnt;
        active_nxt = active;
        req_nxt    = fire_req;
        case (state)
            IDLE: begin
`ifdef PLAYER_SHOT_AUTOFIRE_EN
                req_nxt = bus.fire;
`else
                if (bus.fire && !fire_d) req_nxt = 1'b1;
`endif
                if (bus.startOfFrame && fire_req) begin
                    state_nxt  = FLYING;
                    active_nxt = 1'b1;
                    req_nxt    = 1'b0;
                    x_nxt      = (px_int + SHOT_OFFSET_X) * MULTIPLIER;
                    y_nxt      = (py_int < SHOT_HEIGHT) ? 0 : (py_int - SHOT_HEIGHT) * MULTIPLIER;
                end
            end
            FLYING: begin
                // A hit retires the shot even if a frame move lands on the same clk.
                if (bus.shotHit) begin
                    state_nxt  = COOLDOWN;
                    active_nxt = 1'b0;
                    cnt_nxt    = COOLDOWN_FRAMES;
                end else if (bus.startOfFrame) begin
                    if (y_fx < Y_SPEED + TOP_LIMIT * MULTIPLIER) begin
                        state_nxt  = COOLDOWN;
                        active_nxt = 1'b0;
                        cnt_nxt    = COOLDOWN_FRAMES;
                    end else begin
                        y_nxt = y_fx - Y_SPEED;
                    end
                end
            end
            COOLDOWN: begin
                if (cnt == 0) begin
                    state_nxt = IDLE;
                end else if (bus.startOfFrame) begin
                    cnt_nxt = cnt - 1;
                    if (cnt == 1) state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt  = IDLE;
                active_nxt = 1'b0;
            end
        endcase
    end

    assign bus.shotActive = active;
    assign bus.topLeftX   = 11'(x_fx >>> 6);
    assign bus.topLeftY   = 11'(y_fx >>> 6);
    assign bus.shot_state = state;
endmodule

// File: tb/tb_player_shot_move.sv
// Directed bench for player_shot_move: launch, flight, retire, cooldown, hit, clamp.
module tb_player_shot_move;
    localparam int ST_IDLE     = 0;
    localparam int ST_FLYING   = 1;
    localparam int ST_COOLDOWN = 2;

    logic clk;
    logic resetN;
    int   checks = 0;
    int   errors = 0;
    int   launches;
    logic prev_active;

    player_shot_move_if bus ();

    player_shot_move dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        bus.startOfFrame = 1'b1;
        tick();
        bus.startOfFrame = 1'b0;
        tick();
    endtask

    task automatic press();
        bus.fire = 1'b1;
        tick();
        bus.fire = 1'b0;
        tick();
    endtask

    task automatic pulse_reset();
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        tick();
    endtask

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input int act, input int x, input int y, input int st);
        check({tag, ".active"}, int'(bus.shotActive), act);
        check({tag, ".x"}, int'(bus.topLeftX), x);
        check({tag, ".y"}, int'(bus.topLeftY), y);
        check({tag, ".state"}, int'(bus.shot_state), st);
    endtask

    initial begin
        resetN           = 1'b0;
        bus.startOfFrame = 1'b0;
        bus.fire         = 1'b0;
        bus.shotHit      = 1'b0;
        bus.playerX      = 11'd320;
        bus.playerY      = 11'd450;
        #1;
        check_out("reset", 0, 0, 0, ST_IDLE);
        tick();
        tick();
        resetN = 1'b1;
        tick();

        // No fire request yet: a frame must not launch
        frame();
        check("no_fire.active", int'(bus.shotActive), 0);

        // Basic launch and first move
        press();
        check("pre_launch.active", int'(bus.shotActive), 0);
        frame();
        check_out("launch", 1, 336, 434, ST_FLYING);
        frame();
        check_out("move1", 1, 336, 430, ST_FLYING);
        bus.playerX = 11'd340;
        frame();
        check_out("move2_px_changed", 1, 336, 426, ST_FLYING);

        // Asynchronous reset mid-flight
        resetN = 1'b0;
        #1;
        check_out("reset_mid_flight", 0, 0, 0, ST_IDLE);
        tick();
        resetN = 1'b1;
        tick();
        bus.playerX = 11'd320;
        press();
        frame();
        check_out("relaunch", 1, 336, 434, ST_FLYING);

        // Fly to the top: 108 moves then retire on the 109th frame
        for (int i = 0; i < 108; i++) frame();
        check_out("top_108", 1, 336, 2, ST_FLYING);
        frame();
        check_out("top_retire", 0, 336, 2, ST_COOLDOWN);
        press();
        for (int i = 0; i < 7; i++) frame();
        check("cooldown_7.state", int'(bus.shot_state), ST_COOLDOWN);
        frame();
        check("cooldown_8.state", int'(bus.shot_state), ST_IDLE);
        frame();
        check("cooldown_fire_dropped", int'(bus.shotActive), 0);

        // Hit wins over a simultaneous frame move
        bus.playerY = 11'd416;
        press();
        frame();
        check_out("hit_launch", 1, 336, 400, ST_FLYING);
        for (int i = 0; i < 25; i++) frame();
        check("hit_pre.y", int'(bus.topLeftY), 300);
        bus.shotHit      = 1'b1;
        bus.startOfFrame = 1'b1;
        tick();
        bus.shotHit      = 1'b0;
        bus.startOfFrame = 1'b0;
        check_out("hit_priority", 0, 336, 300, ST_COOLDOWN);
        bus.shotHit = 1'b1;
        for (int i = 0; i < 8; i++) frame();
        bus.shotHit = 1'b0;
        check_out("hit_cooldown_done", 0, 336, 300, ST_IDLE);

        // Held fire for 200 frames
        bus.playerY = 11'd316;
        bus.fire    = 1'b1;
        tick();
        launches    = 0;
        prev_active = bus.shotActive;
        for (int i = 0; i < 200; i++) begin
            frame();
            if (bus.shotActive && !prev_active) launches++;
            prev_active = bus.shotActive;
        end
        bus.fire = 1'b0;
        tick();
`ifdef PLAYER_SHOT_AUTOFIRE_EN
        check("held_fire.launches", launches, 3);
`else
        check("held_fire.launches", launches, 1);
        check("held_fire.state", int'(bus.shot_state), ST_IDLE);
`endif
        pulse_reset();

        // Launch clamp near the top edge
        bus.playerY = 11'd10;
        press();
        frame();
        check_out("clamp_launch", 1, 336, 0, ST_FLYING);
        frame();
        check_out("clamp_retire", 0, 336, 0, ST_COOLDOWN);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
